// File: rtl/data_sram_resp.sv
// Data-side SRAM-like responder: accepts byte-strobed writes and word reads,
// returns in-order responses after a fixed latency through a bounded queue.
module data_sram_resp #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned RESP_LAT  = 2,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        acc_stall,
  input  logic        resp_stall,
  output logic        align_err
);

  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic          wr;
    logic [31:0]   data;
    logic [CW-1:0] cnt;
  } entry_t;

  logic [31:0]      mem [MEM_WORDS];
  entry_t           q [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      occ;

  logic          full;
  logic          accept;
  logic          pop;
  logic          misaligned;
  logic [IW-1:0] idx;
  logic          unused_addr;

  assign idx         = data_sram_addr[IW+1:2];
  assign unused_addr = ^data_sram_addr[31:IW+2];
  assign full        = (occ == (PW+1)'(DEPTH));

  assign data_sram_addr_ok = ~reset & ~full & ~acc_stall;
  assign accept            = data_sram_req & data_sram_addr_ok;

  // Head responds once its latency has elapsed; pop happens on the same edge.
  assign data_sram_data_ok = ~reset & q_vld[head] & (q[head].cnt == '0) & ~resp_stall;
  assign pop               = data_sram_data_ok;
  assign data_sram_rdata   = (pop & ~q[head].wr) ? q[head].data : 32'h0;

  always_comb begin
    misaligned = 1'b0;
    case (data_sram_size)
      2'd1:    misaligned = data_sram_addr[0];
      2'd2:    misaligned = (data_sram_addr[1:0] != 2'b00);
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Word array; writes commit at acceptance and are never reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) begin
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Entry payload: latency countdown plus snapshot of the pre-edge word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && (q[i].cnt != '0)) begin
        q[i].cnt <= q[i].cnt - CW'(1);
      end
    end
    if (accept) begin
      q[tail].wr   <= data_sram_wr;
      q[tail].data <= data_sram_wr ? 32'h0 : mem[idx];
      q[tail].cnt  <= CW'(RESP_LAT - 1);
    end
  end

  // Queue control and sticky alignment flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_vld     <= '0;
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      align_err <= 1'b0;
    end else begin
      if (pop) begin
        q_vld[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (accept) begin
        q_vld[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      case ({accept, pop})
        2'b10:   occ <= occ + (PW+1)'(1);
        2'b01:   occ <= occ - (PW+1)'(1);
        default: occ <= occ;
      endcase
      if (accept && misaligned) begin
        align_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: stimulus pushes expected responses,
// a negedge monitor pops and compares on every data_ok.
module tb_data_sram_resp;

  localparam int unsigned LAT = 2;

  logic        clk;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        acc_stall;
  logic        resp_stall;
  logic        align_err;

  data_sram_resp #(.MEM_WORDS(1024), .RESP_LAT(LAT), .DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_addr    (addr),
    .data_sram_wstrb   (wstrb),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .acc_stall         (acc_stall),
    .resp_stall        (resp_stall),
    .align_err         (align_err)
  );

  typedef struct {
    logic [31:0] data;
    int          acc;
    bit          exact;
  } exp_t;

  exp_t sb[$];
  int   pop_log[$];
  int   cyc;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  // Monitor: every response must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (data_ok === 1'b1) begin
      pop_log.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_ok: got data_ok with empty scoreboard rdata 0x%08h (cycle %0d)", rdata, cyc);
      end else begin
        e = sb.pop_front();
        check("rdata", rdata, e.data);
        if (e.exact) check("resp_cycle", 32'(cyc), 32'(e.acc + int'(LAT)));
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] sz,
                       input logic [31:0] exp_d, input bit exact, output int acc);
    int n;
    exp_t e;
    n = 0;
    acc = -1;
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = sz;
    @(negedge clk);
    while (addr_ok !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (addr_ok !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: addr_ok stayed low for addr 0x%08h", a);
    end else begin
      acc = cyc;
      e.data = exp_d; e.acc = cyc; e.exact = exact;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses still pending, expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int rc;
    req = 0; wr = 0; size = 2'd2; addr = 0; wstrb = 0; wdata = 0;
    acc_stall = 0; resp_stall = 0;
    reset = 1'b1;
    checks = 0; errors = 0;

    // Reset values
    @(negedge clk);
    check("reset_addr_ok", 32'(addr_ok), 32'd0);
    check("reset_data_ok", 32'(data_ok), 32'd0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_align_err", 32'(align_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_addr_ok", 32'(addr_ok), 32'd1);
    @(posedge clk); #1;

    // Write then read back-to-back, exact latency
    issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 2'd2, 32'h0, 1, acc);
    issue(0, 32'h10, 32'h0, 4'h0, 2'd2, 32'hDEADBEEF, 1, acc);
    drain();

    // Byte strobes
    issue(1, 32'h20, 32'h11223344, 4'hF, 2'd2, 32'h0, 1, acc);
    issue(1, 32'h20, 32'hAABBCCDD, 4'b0100, 2'd2, 32'h0, 1, acc);
    issue(0, 32'h20, 32'h0, 4'h0, 2'd2, 32'h11BB3344, 1, acc);
    drain();

    // Read-after-write ordering and address wrap
    issue(1, 32'h30, 32'h12345678, 4'hF, 2'd2, 32'h0, 1, acc);
    issue(0, 32'h30, 32'h0, 4'h0, 2'd2, 32'h12345678, 1, acc);
    issue(1, 32'h30, 32'h5, 4'hF, 2'd2, 32'h0, 1, acc);
    issue(0, 32'h30, 32'h0, 4'h0, 2'd2, 32'h5, 1, acc);
    issue(0, 32'h1010, 32'h0, 4'h0, 2'd2, 32'hDEADBEEF, 1, acc);
    drain();

    // Full queue under resp_stall
    for (int i = 0; i < 5; i++)
      issue(1, 32'h100 + 32'(4*i), 32'hC0DE0000 + 32'(i), 4'hF, 2'd2, 32'h0, 0, acc);
    drain();
    pop_log.delete();
    resp_stall = 1'b1;
    for (int i = 0; i < 4; i++)
      issue(0, 32'h100 + 32'(4*i), 32'h0, 4'h0, 2'd2, 32'hC0DE0000 + 32'(i), 0, acc);
    req = 1'b1; wr = 1'b0; addr = 32'h110;
    @(negedge clk);
    check("full_addr_ok", 32'(addr_ok), 32'd0);
    check("stalled_data_ok", 32'(data_ok), 32'd0);
    @(posedge clk); #1;
    resp_stall = 1'b0;
    rc = cyc;
    issue(0, 32'h110, 32'h0, 4'h0, 2'd2, 32'hC0DE0004, 0, acc);
    check("fifth_accept_cycle", 32'(acc), 32'(rc + 1));
    drain();
    check("pop_count", 32'(pop_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < pop_log.size()) check("pop_cycle", 32'(pop_log[i]), 32'(rc + i));

    // Sticky alignment error; aligned half access does not set it
    issue(0, 32'h12, 32'h0, 4'h0, 2'd1, 32'hDEADBEEF, 1, acc);
    check("aligned_half_no_err", 32'(align_err), 32'd0);
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h22;
    @(negedge clk);
    check("align_err_before", 32'(align_err), 32'd0);
    sb.push_back('{data: 32'h11BB3344, acc: cyc, exact: 1'b1});
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("align_err_rise", 32'(align_err), 32'd1);
    @(posedge clk); #1;
    issue(0, 32'h30, 32'h0, 4'h0, 2'd2, 32'h5, 1, acc);
    drain();
    check("align_err_sticky", 32'(align_err), 32'd1);

    // Reset with three outstanding requests
    resp_stall = 1'b1;
    for (int i = 0; i < 3; i++)
      issue(0, 32'h100, 32'h0, 4'h0, 2'd2, 32'hC0DE0000, 0, acc);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_addr_ok", 32'(addr_ok), 32'd0);
    check("rst_data_ok", 32'(data_ok), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    resp_stall = 1'b0;
    @(negedge clk);
    check("rst_release_addr_ok", 32'(addr_ok), 32'd1);
    check("rst_align_err_clear", 32'(align_err), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("no_stale_data_ok", 32'(data_ok), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    issue(0, 32'h10, 32'h0, 4'h0, 2'd2, 32'hDEADBEEF, 1, acc);
    issue(0, 32'h20, 32'h0, 4'h0, 2'd2, 32'h11BB3344, 1, acc);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Data-side SRAM-like responder: the slave end of the CPU data interface whose request/response handshake the memory stage consumes. It accepts requests (`addr_ok`), performs byte-strobed writes and word reads on an internal word array, and returns in-order responses (`data_ok`, `rdata`) after a fixed, parameterised latency. A bounded outstanding-request queue, plus two stall inputs for back-pressure injection, make it the simulation data memory for the pipeline and the bench's timing-variation source.

## Interface
- `MEM_WORDS`, 1024: word count, power of two; index = `addr[$clog2(MEM_WORDS)+1:2]`.
- `RESP_LAT`, 2: cycles from acceptance to earliest `data_ok`; legal 1..15.
- `DEPTH`, 4: maximum outstanding requests; power of two, ≥2.
- `clk` in 1: sole clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `data_sram_req` in 1: request valid.
- `data_sram_wr` in 1: 1 = write, 0 = read.
- `data_sram_size` in 2: 0 byte, 1 half, 2 word; alignment checking only.
- `data_sram_addr` in 32: byte address.
- `data_sram_wstrb` in 4: byte enables for writes.
- `data_sram_wdata` in 32: write data.
- `data_sram_addr_ok` out 1: request accepted this cycle when `req` also high.
- `data_sram_data_ok` out 1: one-cycle response pulse per accepted request.
- `data_sram_rdata` out 32: read word, valid with `data_ok`.
- `acc_stall` in 1: forces `addr_ok` low.
- `resp_stall` in 1: forces `data_ok` low.
- `align_err` out 1: sticky misaligned-access flag.

## Operation
- Accept = `req & addr_ok`. `addr_ok = ~reset & ~full & ~acc_stall`; independent of `req`.
- On accept, at that edge:
  - write: for each `wstrb[i]`, byte i of word[index] ← `wdata[8i+7:8i]`.
  - read: word[index] (after any same-edge write logic, i.e. pre-edge contents) is snapshotted into the queue entry.
  - push entry {wr, snapshot, cnt = RESP_LAT-1}.
- Writes commit at acceptance, so later reads see them; earlier reads keep their snapshot (strict program order).
- Queue: circular buffer, head/tail pointers wrap modulo DEPTH, occupancy 0..DEPTH. `full` = occupancy == DEPTH; `empty` = occupancy == 0.
- Every cycle each valid entry with cnt > 0 decrements; cnt saturates at 0.
- `data_ok = head valid & head cnt == 0 & ~resp_stall`; on `data_ok`, pop head at the edge.
- `rdata` = head snapshot when `data_ok` and head is a read; otherwise 32'h0. Writes return `data_ok` with rdata 0.
- Push and pop in the same cycle: occupancy unchanged, both pointers advance. When full, no push occurs even if a pop happens that cycle (no bypass; `addr_ok` stays low).
- `align_err` set on accept when (size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | size==3. Cleared only by reset. The access is still performed.
- Address bits above the index and `addr[1:0]` are ignored for indexing; addresses wrap onto the array.
- Reset: queue emptied, pointers and occupancy 0, `align_err` 0. Array contents are not reset. Requests in flight at reset are discarded, with no `data_ok`.

## Timing
- Reset values: `addr_ok` 0 during the reset cycle, then 1 (stalls low); `data_ok` 0; `rdata` 0; `align_err` 0.
- Accept in cycle t, with no stall and an empty queue: `data_ok` in cycle t+RESP_LAT.
- Throughput: one accept and one response per cycle. Back-to-back accepts produce back-to-back `data_ok` pulses, RESP_LAT later.
- `resp_stall` high in cycle c: no pop. The head keeps cnt 0 and responds in the first cycle with `resp_stall` low.
- Up to DEPTH accepts outstanding. The (DEPTH+1)th is held until the edge after a pop.

## Test plan
- RESP_LAT=2: write addr 0x10 data 0xDEADBEEF wstrb 4'hF at t0, read 0x10 at t1 -> `data_ok` at t2 (rdata 0) and t3 (rdata 0xDEADBEEF).
- Byte strobes: word 0x20 = 0x11223344; write wdata 0xAABBCCDD wstrb 4'b0100, then read -> rdata 0x11BB3344.
- Full queue: DEPTH=4, `resp_stall`=1, 5 consecutive reads -> 4 accepted, `addr_ok` 0 for the 5th. Release stall -> 4 in-order `data_ok` pulses on consecutive cycles. 5th accepted the cycle after the first pop.
- Read-after-write ordering: read A, write A=0x5, read A, accepted back-to-back -> rdata old value, 0, then 0x5.
- Misaligned: size=2 addr 0x22 -> `align_err` rises the next cycle and stays 1 through later aligned traffic until reset.
- Reset with 3 outstanding: no `data_ok` after reset. `addr_ok`=1 the cycle after reset deasserts. Array data written before reset is still readable.
